i2c_target_responder: RTL and testbench
=======================================

Name: i2c_target_responder

Overview:
- Single-lane I2C target (responder) serving the LC3 I2C master on one SDA line of the bus. It is the device end that today's bench models with a bare ACK driver.
- Oversamples SCL/SDA with the system clock, detects START/STOP, matches a 7-bit device address, and ACKs each byte.
- Write transfers land in an internal 8-bit register file; read transfers stream from it.
- Drives SDA open-drain only, via a pull-low enable. The host-side read port exposes the register file to local logic.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address the target responds to.
- DEPTH, 16, number of 8-bit registers; power of two.
- PTR_W, 4, register pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; must be at least 10x the SCL frequency.
- rst_n  in  1  asynchronous active-low reset.
- scl_in  in  1  SCL line, asynchronous to clk.
- sda_in  in  1  SDA line as resolved on the bus, asynchronous to clk.
- sda_oe  out  1  1 = pull SDA low, 0 = release (high-Z, pulled up externally).
- host_addr  in  PTR_W  host-side read address.
- host_data  out  8  register[host_addr], combinational read.
- wr_strobe  out  1  one-cycle pulse when a data byte is committed to the register file.
- wr_index  out  PTR_W  register index of the committed byte; valid with wr_strobe.
- busy  out  1  high from an address-matched START until STOP or mismatch.

Behaviour:
- Reset (async, rst_n=0): sda_oe=0, wr_strobe=0, wr_index=0, busy=0, pointer=0, all registers=0, FSM=IDLE. Synchronizers are preset to 1, so no false START fires on release.
- Input conditioning: scl_in and sda_in each pass through a 2-flop synchronizer plus a history flop.
  - scl_rise / scl_fall = edge of the synchronized SCL.
  - START = synchronized SDA 1->0 while synchronized SCL=1.
  - STOP = synchronized SDA 0->1 while synchronized SCL=1.
- SDA timing rules:
  - The FSM samples SDA only on scl_rise.
  - The FSM changes sda_oe only on the cycle after scl_fall. sda_oe must therefore settle at most 3 clk after the real SCL falling edge.
- Bit counter: 3 bits, MSB first. The byte completes on the 8th scl_rise.
- FSM states and transitions:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits. Upper 7 bits == DEV_ADDR -> A_ACK with the R/W bit latched, busy=1. Otherwise -> WAIT_STOP; sda_oe stays 0 (NACK by silence).
  - A_ACK: drive sda_oe=1 for one SCL period, released after the next scl_fall. Then W=0 -> W_PTR; R=1 -> RD_DATA, loading shift reg with reg[pointer].
  - W_PTR: shift 8 bits. Pointer = low PTR_W bits; upper bits ignored. -> W_PTR_ACK (ACK as above) -> W_DATA.
  - W_DATA: shift 8 bits. On the 8th bit write reg[pointer], pulse wr_strobe with wr_index=pointer, then pointer++ (wraps DEPTH-1 -> 0). -> W_ACK (ACK) -> W_DATA.
  - RD_DATA: after each scl_fall, drive sda_oe = ~shift[7] and shift left. After 8 bits, release -> RD_ACK.
  - RD_ACK: sample master SDA on scl_rise.
    - 0 (ACK): pointer++ (wrap), load the next byte -> RD_DATA.
    - 1 (NACK): -> WAIT_STOP.
  - WAIT_STOP: sda_oe=0, busy=0; ignore bits until STOP or START.
- Global overrides, taking priority over every state:
  - STOP in any state -> IDLE, sda_oe=0, busy=0. A partial byte is discarded and the register is not written.
  - START (including repeated START) in any state -> ADDR, bit counter cleared, sda_oe=0. The pointer is kept, so write-pointer-then-repeated-START-read works.
- Simultaneous events: host_addr reads during an I2C write see the old value until the commit cycle, then the new value. There is no read-during-write hazard beyond that.
- The target never stretches SCL.

Decomposition:
- Shared package i2c_pkg holds:
  - the state encoding (localparams S_IDLE .. S_WAIT_STOP);
  - I2C_RW_READ=1;
  - the default DEV_ADDR constant.
- One sub-module, i2c_line_sync: the 2-flop synchronizer with history flop. It outputs the level, rise and fall for one line, is instantiated once for SCL and once for SDA, and START/STOP decode sits in the parent.
- The register file is inline.

Test Plan:
- Write burst: START, 0xA0, 0x03, 0xA5, 0x3C, STOP.
  - Required: 4 ACKs (sda_oe=1 during each 9th SCL high).
  - Required: wr_strobe twice with wr_index 3 then 4.
  - Required: host_addr=3 -> 0xA5, host_addr=4 -> 0x3C.
- Pointer-set then read: START, 0xA0, 0x03, repeated START, 0xA1, read 2 bytes (master ACK then NACK), STOP.
  - Required: SDA carries 0xA5 then 0x3C.
  - Required: sda_oe=0 after the NACK.
- Wrap-around: write 0x0F then 3 data bytes 0x11, 0x22, 0x33.
  - Required: reg15=0x11, reg0=0x22, reg1=0x33.
- Address mismatch: START, 0xA2, 0x55, STOP.
  - Required: sda_oe stays 0 for the whole transfer, busy=0, no wr_strobe.
- Abort: STOP after 5 bits of a data byte.
  - Required: register unchanged, no wr_strobe, FSM in IDLE, sda_oe=0.
  - Then rst_n low mid-read (while sda_oe=1): sda_oe=0 within the same cycle and all registers read 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target responder.
//   state_t          : protocol FSM state encoding
//   I2C_RW_READ      : value of the R/W bit that requests a read
//   DEFAULT_DEV_ADDR : default 7-bit device address
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_A_ACK     = 4'd2,
    S_W_PTR     = 4'd3,
    S_W_PTR_ACK = 4'd4,
    S_W_DATA    = 4'd5,
    S_W_ACK     = 4'd6,
    S_RD_DATA   = 4'd7,
    S_RD_ACK    = 4'd8,
    S_WAIT_STOP = 4'd9
  } state_t;

  localparam logic       I2C_RW_READ      = 1'b1;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;

endpackage

// File: rtl/i2c_target_responder_if.sv
// I2C bus-side signals of the target.
//   scl_in : SCL line level (driven by the bus / master)
//   sda_in : resolved SDA line level
//   sda_oe : 1 = target pulls SDA low, 0 = released
// Modports: slave = the target, master = the bus / master model.
interface i2c_target_responder_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport slave  (input scl_in, input sda_in, output sda_oe);
  modport master (output scl_in, output sda_in, input sda_oe);
endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus history flop for one asynchronous line.
//   clk, rst_n : system clock, async active-low reset (flops preset to 1)
//   line_in    : asynchronous input line
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized edges
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic hist_reg;

  // Preset to 1 (idle bus level) so releasing reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      hist_reg <= 1'b1;
    end else begin
      meta_reg <= line_in;
      sync_reg <= meta_reg;
      hist_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign rise  = sync_reg & ~hist_reg;
  assign fall  = ~sync_reg & hist_reg;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target with an internal 8-bit register file.
//   clk, rst_n : system clock (>= 10x SCL), async active-low reset
//   bus        : SCL/SDA inputs and open-drain SDA pull-low enable
//   host_addr  : local read address; host_data = reg[host_addr] (combinational)
//   wr_strobe  : one-cycle pulse when an I2C data byte is committed
//   wr_index   : register index of the committed byte
//   busy       : high from an address match until STOP or mismatch
// Write: START, addr+W, pointer, data... STOP. Read: START, addr+R, data...
// The pointer auto-increments and survives a repeated START.
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
  parameter int         DEPTH    = 16,
  parameter int         PTR_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  i2c_target_responder_if.slave  bus,
  input  logic [PTR_W-1:0]       host_addr,
  output logic [7:0]             host_data,
  output logic                   wr_strobe,
  output logic [PTR_W-1:0]       wr_index,
  output logic                   busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .clk(clk), .rst_n(rst_n), .line_in(bus.scl_in),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk(clk), .rst_n(rst_n), .line_in(bus.sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  state_t           state_reg, state_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic             rw_reg, rw_next;
  logic             sda_oe_reg, sda_oe_next;
  logic             busy_reg, busy_next;
  logic             wr_strobe_reg;
  logic [PTR_W-1:0] wr_index_reg, wr_index_next;
  logic             mem_we;
  logic [7:0]       bit_next;
  logic [7:0]       rd_byte;

  logic [7:0] mem [DEPTH];

  assign host_data = mem[host_addr];
  assign bit_next  = {shift_reg[6:0], sda_lvl};
  assign rd_byte   = mem[ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      ptr_reg       <= '0;
      rw_reg        <= 1'b0;
      sda_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_index_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      ptr_reg       <= ptr_next;
      rw_reg        <= rw_next;
      sda_oe_reg    <= sda_oe_next;
      busy_reg      <= busy_next;
      wr_strobe_reg <= mem_we;
      wr_index_reg  <= wr_index_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[ptr_reg] <= bit_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    ptr_next      = ptr_reg;
    rw_next       = rw_reg;
    sda_oe_next   = sda_oe_reg;
    busy_next     = busy_reg;
    wr_index_next = wr_index_reg;
    mem_we        = 1'b0;

    if (stop_det) begin
      state_next   = S_IDLE;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else if (start_det) begin
      state_next   = S_ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: ;

        S_ADDR: begin
          if (scl_rise) begin
            shift_next   = bit_next;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (bit_next[7:1] == DEV_ADDR) begin
                state_next = S_A_ACK;
                rw_next    = bit_next[0];
                busy_next  = 1'b1;
              end else begin
                state_next = S_WAIT_STOP;
                busy_next  = 1'b0;
              end
            end
          end
        end

        // ACK states see two falls: the one ending bit 8 (assert) and the
        // one ending the ACK clock (release). sda_oe tells them apart.
        S_A_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = 1'b1;
            end else if (rw_reg == I2C_RW_READ) begin
              // Bit 7 must be on the line before the next rise, so it is
              // driven on the same fall that releases the ACK.
              state_next   = S_RD_DATA;
              sda_oe_next  = ~rd_byte[7];
              shift_next   = {rd_byte[6:0], 1'b0};
              bit_cnt_next = 3'd1;
            end else begin
              state_next   = S_W_PTR;
              sda_oe_next  = 1'b0;
              bit_cnt_next = '0;
            end
          end
        end

        S_W_PTR: begin
          if (scl_rise) begin
            shift_next   = bit_next;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              ptr_next   = bit_next[PTR_W-1:0];
              state_next = S_W_PTR_ACK;
            end
          end
        end

        S_W_DATA: begin
          if (scl_rise) begin
            shift_next   = bit_next;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              mem_we        = 1'b1;
              wr_index_next = ptr_reg;
              ptr_next      = ptr_reg + PTR_W'(1);
              state_next    = S_W_ACK;
            end
          end
        end

        S_W_PTR_ACK, S_W_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = 1'b1;
            end else begin
              sda_oe_next  = 1'b0;
              state_next   = S_W_DATA;
              bit_cnt_next = '0;
            end
          end
        end

        // bit_cnt counts bits already driven; it wraps to 0 after bit 0,
        // and the following fall releases the line for the master's ACK.
        S_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 3'd0) begin
              sda_oe_next = 1'b0;
              state_next  = S_RD_ACK;
            end else begin
              sda_oe_next  = ~shift_reg[7];
              shift_next   = {shift_reg[6:0], 1'b0};
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end
        end

        // Entered on a fall, so the rise (master ACK/NACK) comes first;
        // a fall seen here therefore always follows an ACK.
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_lvl) begin
              state_next = S_WAIT_STOP;
              busy_next  = 1'b0;
            end else begin
              ptr_next = ptr_reg + PTR_W'(1);
            end
          end else if (scl_fall) begin
            state_next   = S_RD_DATA;
            sda_oe_next  = ~rd_byte[7];
            shift_next   = {rd_byte[6:0], 1'b0};
            bit_cnt_next = 3'd1;
          end
        end

        S_WAIT_STOP: begin
          sda_oe_next = 1'b0;
          busy_next   = 1'b0;
        end

        default: state_next = S_IDLE;
      endcase
    end
  end

  assign bus.sda_oe = sda_oe_reg;
  assign wr_strobe  = wr_strobe_reg;
  assign wr_index   = wr_index_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_i2c_target_responder.sv
module tb_i2c_target_responder;
  import i2c_pkg::*;

  localparam int Q = 5;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] host_addr = '0;
  logic [7:0] host_data;
  logic       wr_strobe;
  logic [3:0] wr_index;
  logic       busy;

  int tests = 0;
  int fails = 0;

  int strobe_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  logic [3:0] idx_log [$];

  i2c_target_responder_if bus ();

  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_target_responder #(.DEV_ADDR(7'h50), .DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .host_addr(host_addr), .host_data(host_data),
    .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      idx_log.push_back(wr_index);
    end
    if (bus.sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  // Works both from idle (SCL high) and as a repeated START (SCL low).
  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = bus.sda_oe;
    wait_q();
    scl_m = 1'b0; wait_q();
    $display("[TB] write 0x%02h ack=%0b", d, ack);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = bus.sda_in;
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(~m_ack);
    $display("[TB] read 0x%02h master_ack=%0b", d, m_ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    logic       b;
    int         s0;
    int         oe0;
    int         busy0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_wr_index", 32'(wr_index), 32'd0);
    host_addr = 4'd0; #1;
    chk("rst_reg0", 32'(host_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    wait_q();

    // Write burst: A0 03 A5 3C
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hA0, ack); chk("wb_ack_addr", 32'(ack), 32'd1);
    chk("wb_busy", 32'(busy), 32'd1);
    write_byte(8'h03, ack); chk("wb_ack_ptr", 32'(ack), 32'd1);
    write_byte(8'hA5, ack); chk("wb_ack_d0", 32'(ack), 32'd1);
    write_byte(8'h3C, ack); chk("wb_ack_d1", 32'(ack), 32'd1);
    i2c_stop();
    chk("wb_strobes", 32'(strobe_cnt - s0), 32'd2);
    chk("wb_idx0", 32'(idx_log[s0]), 32'd3);
    chk("wb_idx1", 32'(idx_log[s0+1]), 32'd4);
    chk("wb_busy_after_stop", 32'(busy), 32'd0);
    host_addr = 4'd3; #1; chk("wb_reg3", 32'(host_data), 32'hA5);
    host_addr = 4'd4; #1; chk("wb_reg4", 32'(host_data), 32'h3C);
    $display("[TB] write burst done");

    // Pointer set, repeated START, read two bytes
    i2c_start();
    write_byte(8'hA0, ack); chk("rd_ack_addr_w", 32'(ack), 32'd1);
    write_byte(8'h03, ack); chk("rd_ack_ptr", 32'(ack), 32'd1);
    i2c_start();
    write_byte(8'hA1, ack); chk("rd_ack_addr_r", 32'(ack), 32'd1);
    read_byte(1'b1, rd); chk("rd_byte0", 32'(rd), 32'hA5);
    read_byte(1'b0, rd); chk("rd_byte1", 32'(rd), 32'h3C);
    chk("rd_oe_after_nack", 32'(bus.sda_oe), 32'd0);
    chk("rd_busy_after_nack", 32'(busy), 32'd0);
    i2c_stop();
    chk("rd_oe_after_stop", 32'(bus.sda_oe), 32'd0);

    // Pointer wrap-around
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h0F, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    write_byte(8'h33, ack); chk("wrap_ack_last", 32'(ack), 32'd1);
    i2c_stop();
    chk("wrap_strobes", 32'(strobe_cnt - s0), 32'd3);
    chk("wrap_idx1", 32'(idx_log[s0+1]), 32'd0);
    host_addr = 4'd15; #1; chk("wrap_reg15", 32'(host_data), 32'h11);
    host_addr = 4'd0;  #1; chk("wrap_reg0", 32'(host_data), 32'h22);
    host_addr = 4'd1;  #1; chk("wrap_reg1", 32'(host_data), 32'h33);

    // Address mismatch
    s0 = strobe_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
    i2c_start();
    write_byte(8'hA2, ack); chk("mm_ack_addr", 32'(ack), 32'd0);
    write_byte(8'h55, ack);
    i2c_stop();
    chk("mm_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
    chk("mm_busy_cycles", 32'(busy_cnt - busy0), 32'd0);
    chk("mm_strobes", 32'(strobe_cnt - s0), 32'd0);

    // Abort: STOP after 5 bits of a data byte to register 5
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    i2c_stop();
    chk("ab_strobes", 32'(strobe_cnt - s0), 32'd0);
    host_addr = 4'd5; #1; chk("ab_reg5", 32'(host_data), 32'h00);
    chk("ab_state", 32'(dut.state_reg), 32'(S_IDLE));
    chk("ab_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    $display("[TB] abort done");

    // Reset while driving a 0 data bit (reg3 = A5, bit6 = 0)
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h03, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    read_bit(b); chk("mr_bit7", 32'(b), 32'd1);
    chk("mr_oe_driving", 32'(bus.sda_oe), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_oe_async", 32'(bus.sda_oe), 32'd0);
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i); #1;
      chk($sformatf("mr_reg%0d", i), 32'(host_data), 32'h00);
    end
    scl_m = 1'b1; sda_m = 1'b1;
    wait_q();
    rst_n = 1'b1;
    wait_q();
    $display("[TB] reset mid-read done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
